// File: rtl/cache_fill_fsm_if.sv
// Cache-miss fill bus: CPU-side miss request, memory read/return channel,
// and the data/tag array write port driven by the fill controller.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              fsm_busy;
  logic              memory_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] cache_address;
  logic [15:0]       cache_data;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_en, memory_address, write_data_array,
           write_tag_array, cache_address, cache_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_en, memory_address, write_data_array,
           write_tag_array, cache_address, cache_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues one memory read per block word back-to-back
// and streams in-order returns into the data array, writing the tag on the last word.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int OFF_W  = 4
) (
  input logic             clk,
  input logic             rst,
  cache_fill_fsm_if.master bus
);
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  reqCnt;
  logic [CNT_W-1:0]  rcvCnt;
  logic              reqActive;
  logic              lastBeat;
  logic [ADDR_W-1:0] reqOff;
  logic [ADDR_W-1:0] rcvOff;

  assign reqActive = (state == FILL) && (reqCnt < CNT_W'(WORDS));
  assign lastBeat  = (state == FILL) && bus.memory_data_valid &&
                     (rcvCnt == CNT_W'(WORDS - 1));
  // Word index to byte offset; base is block-aligned so no carry leaves the block.
  assign reqOff    = ADDR_W'({reqCnt, 1'b0});
  assign rcvOff    = ADDR_W'({rcvCnt[IDX_W-1:0], 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base   <= '0;
      reqCnt <= '0;
      rcvCnt <= '0;
    end else if (state == IDLE) begin
      if (bus.miss_detected) begin
        base   <= bus.miss_address & ~OFF_MASK;
        reqCnt <= '0;
        rcvCnt <= '0;
      end
    end else begin
      if (reqActive)             reqCnt <= reqCnt + CNT_W'(1);
      if (bus.memory_data_valid) rcvCnt <= rcvCnt + CNT_W'(1);
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.miss_detected) stateNext = FILL;
      FILL:    if (lastBeat)          stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.fsm_busy         = (state == FILL);
    bus.memory_en        = reqActive;
    bus.memory_address   = base + reqOff;
    bus.write_data_array = (state == FILL) && bus.memory_data_valid;
    bus.write_tag_array  = lastBeat;
    bus.cache_address    = base + rcvOff;
    bus.cache_data       = bus.memory_data;
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: memory latency 4, block of 8 words.
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;

  cache_fill_fsm_if #(.ADDR_W(16)) bus ();

  cache_fill_fsm #(.ADDR_W(16), .WORDS(8), .OFF_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the current cycle (miss sampled at its closing edge); cycle k
  // is checked 2 time units after edge k-1. Requests are in cycles 1..8, data
  // returns start in cycle 5. With gap=1 valids come every other cycle.
  task automatic run_fill(input logic [15:0] addr, input logic [15:0] expBase,
                          input bit gap, input bit holdMiss,
                          input logic [15:0] nextAddr, input string name);
    int nV;
    int last;
    bit vld;
    logic [15:0] d;
    logic [15:0] expAddr;
    bit expBusy, expEn, expWr, expTag;
    nV = 0;
    last = gap ? 19 : 12;
    bus.miss_detected = 1'b1;
    bus.miss_address = addr;
    bus.memory_data_valid = 1'b0;
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      if (!holdMiss) bus.miss_detected = 1'b0;
      if (holdMiss && k == 2) bus.miss_address = nextAddr;
      if (k == last + 1) vld = 1'b1;
      else if (gap)      vld = (k >= 5) && (((k - 5) % 2) == 0);
      else               vld = (k >= 5) && (k <= 12);
      d = 16'hC000 | 16'(k);
      bus.memory_data_valid = vld;
      bus.memory_data = d;
      #1;
      expBusy = (k <= last);
      expEn   = (k <= 8);
      expWr   = vld && (k <= last);
      expTag  = (k == last);
      nTests++;
      if (bus.fsm_busy !== expBusy) begin
        nFail++;
        $display("FAIL %s.busy cyc=%0d got %0b exp %0b", name, k, bus.fsm_busy, expBusy);
      end
      nTests++;
      if (bus.memory_en !== expEn) begin
        nFail++;
        $display("FAIL %s.mem_en cyc=%0d got %0b exp %0b", name, k, bus.memory_en, expEn);
      end
      if (expEn) begin
        expAddr = expBase + 16'(2 * (k - 1));
        nTests++;
        if (bus.memory_address !== expAddr) begin
          nFail++;
          $display("FAIL %s.mem_addr cyc=%0d got %h exp %h", name, k, bus.memory_address, expAddr);
        end
      end
      nTests++;
      if (bus.write_data_array !== expWr) begin
        nFail++;
        $display("FAIL %s.wr_data cyc=%0d got %0b exp %0b", name, k, bus.write_data_array, expWr);
      end
      if (expWr) begin
        expAddr = expBase + 16'(2 * nV);
        nV++;
        nTests++;
        if (bus.cache_address !== expAddr) begin
          nFail++;
          $display("FAIL %s.cache_addr cyc=%0d got %h exp %h", name, k, bus.cache_address, expAddr);
        end
      end
      nTests++;
      if (bus.write_tag_array !== expTag) begin
        nFail++;
        $display("FAIL %s.wr_tag cyc=%0d got %0b exp %0b", name, k, bus.write_tag_array, expTag);
      end
      nTests++;
      if (bus.cache_data !== d) begin
        nFail++;
        $display("FAIL %s.cache_data cyc=%0d got %h exp %h", name, k, bus.cache_data, d);
      end
    end
  endtask

  task automatic test_reset();
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    bus.memory_data_valid = 1'b0;
    bus.memory_data = 16'hA5A5;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    nTests++;
    if ({bus.fsm_busy, bus.memory_en, bus.write_data_array, bus.write_tag_array} !== 4'b0000) begin
      nFail++;
      $display("FAIL reset.ctrl got %b exp 0000",
               {bus.fsm_busy, bus.memory_en, bus.write_data_array, bus.write_tag_array});
    end
    nTests++;
    if (bus.memory_address !== 16'h0000 || bus.cache_address !== 16'h0000) begin
      nFail++;
      $display("FAIL reset.addr got %h/%h exp 0000/0000", bus.memory_address, bus.cache_address);
    end
    nTests++;
    if (bus.cache_data !== 16'hA5A5) begin
      nFail++;
      $display("FAIL reset.cache_data got %h exp a5a5", bus.cache_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Stray valids in IDLE must not write anything.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.memory_data_valid = 1'b1;
      #1;
      nTests++;
      if ({bus.fsm_busy, bus.write_data_array, bus.write_tag_array} !== 3'b000) begin
        nFail++;
        $display("FAIL idle_stray.ctrl got %b exp 000",
                 {bus.fsm_busy, bus.write_data_array, bus.write_tag_array});
      end
    end
    bus.memory_data_valid = 1'b0;
  endtask

  task automatic test_aligned();
    run_fill(16'h1230, 16'h1230, 1'b0, 1'b0, 16'h0000, "aligned");
  endtask

  task automatic test_unaligned();
    run_fill(16'h1236, 16'h1230, 1'b0, 1'b0, 16'h0000, "unaligned");
  endtask

  task automatic test_wrap();
    run_fill(16'hFFFA, 16'hFFF0, 1'b0, 1'b0, 16'h0000, "wrap");
  endtask

  task automatic test_gaps();
    run_fill(16'h0502, 16'h0500, 1'b1, 1'b0, 16'h0000, "gaps");
  endtask

  task automatic test_reset_mid_fill();
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h0084;
    bus.memory_data_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      bus.miss_detected = 1'b0;
      bus.memory_data_valid = (k >= 5);
      #1;
      nTests++;
      if (bus.write_data_array !== (k >= 5)) begin
        nFail++;
        $display("FAIL midrst.pre_wr cyc=%0d got %0b exp %0b", k, bus.write_data_array, (k >= 5));
      end
    end
    nTests++;
    if (bus.cache_address !== 16'h0084) begin
      nFail++;
      $display("FAIL midrst.third_addr got %h exp 0084", bus.cache_address);
    end
    @(posedge clk); #1;
    bus.memory_data_valid = 1'b1;
    rst = 1'b1;
    #1;
    nTests++;
    if ({bus.fsm_busy, bus.memory_en, bus.write_data_array, bus.write_tag_array} !== 4'b0000) begin
      nFail++;
      $display("FAIL midrst.ctrl got %b exp 0000",
               {bus.fsm_busy, bus.memory_en, bus.write_data_array, bus.write_tag_array});
    end
    nTests++;
    if (bus.memory_address !== 16'h0000 || bus.cache_address !== 16'h0000) begin
      nFail++;
      $display("FAIL midrst.addr got %h/%h exp 0000/0000", bus.memory_address, bus.cache_address);
    end
    for (int k = 9; k <= 12; k++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      bus.memory_data_valid = 1'b1;
      #1;
      nTests++;
      if ({bus.fsm_busy, bus.write_data_array, bus.write_tag_array} !== 3'b000) begin
        nFail++;
        $display("FAIL midrst.after cyc=%0d got %b exp 000", k,
                 {bus.fsm_busy, bus.write_data_array, bus.write_tag_array});
      end
    end
    bus.memory_data_valid = 1'b0;
    run_fill(16'h0040, 16'h0040, 1'b0, 1'b0, 16'h0000, "post_rst");
  endtask

  task automatic test_back_to_back();
    run_fill(16'h2000, 16'h2000, 1'b0, 1'b1, 16'h3456, "held1");
    run_fill(16'h3456, 16'h3450, 1'b0, 1'b0, 16'h0000, "held2");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_wrap();
    test_gaps();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between one cache (I- or D-side) and the multi-cycle main memory. On a cache miss it latches the block-aligned miss address, issues one memory read per word of the block on consecutive cycles, and streams each returned word into the cache data array. On the final word it writes the tag array and releases the stall. One instance serves each cache; the CPU pipeline stalls while `fsm_busy` is high.

## Interface
- `ADDR_W`, 16, byte-address width
- `WORDS`, 8, 16-bit words per cache block (power of two)
- `OFF_W`, 4, block byte-offset bits (= log2(WORDS*2))
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset; one clock, asynchronous, active-high; forces IDLE
- `miss_detected`  in  1  cache miss this cycle, sampled only in IDLE
- `miss_address`  in  ADDR_W  byte address of the missing access
- `memory_data_valid`  in  1  memory returns one word this cycle
- `memory_data`  in  16  returned word
- `fsm_busy`  out  1  fill in progress; stall request to pipeline
- `memory_en`  out  1  read request to memory this cycle
- `memory_address`  out  ADDR_W  address of the current read request
- `write_data_array`  out  1  write `cache_data` into data array this cycle
- `write_tag_array`  out  1  write tag/valid for `cache_address` this cycle
- `cache_address`  out  ADDR_W  word address for the current data-array write
- `cache_data`  out  16  equals `memory_data` (combinational pass-through)

## Operation
- States: IDLE, FILL. Registers: `base` (ADDR_W), `req_cnt` and `rcv_cnt` (log2(WORDS)+1 bits each).
- IDLE: if `miss_detected`, latch `base = {miss_address[ADDR_W-1:OFF_W], OFF_W'b0}`, clear both counters, go to FILL. Otherwise stay.
- FILL, request side: `memory_en = (req_cnt < WORDS)`; `memory_address = base + 2*req_cnt`; `req_cnt` increments each cycle while `memory_en` is high.
- FILL, return side: `write_data_array = memory_data_valid`; `cache_address = base + 2*rcv_cnt[log2(WORDS)-1:0]`; `rcv_cnt` increments on each valid.
- `write_tag_array = FILL & memory_data_valid & (rcv_cnt == WORDS-1)`. Next state is IDLE.
- `fsm_busy = (state == FILL)`.
- In IDLE: `memory_en`, `write_data_array` and `write_tag_array` are 0. `memory_data_valid` is ignored.
- In FILL: `miss_detected` is ignored. A held miss starts a new fill only when sampled in IDLE.
- Address arithmetic is modulo 2^ADDR_W. The offset add never carries out of the block because `base` is aligned.
- Returned words are written in request order; the memory is in-order.

## Timing
- Reset values: state IDLE, counters 0, `base` 0. All outputs 0 except `cache_data`, which follows `memory_data`.
- `miss_detected` sampled at edge E0 -> FILL from E0. `fsm_busy` and the first request (`base`) appear in cycle 1. Requests occupy cycles 1..WORDS back-to-back.
- With memory latency L, data returns in cycles 1+L .. WORDS+L. With WORDS=8 and L=4, tag write is in cycle 12, `fsm_busy` is low in cycle 13, and a new miss can be accepted at the edge ending cycle 13.
- Gaps in `memory_data_valid` are tolerated. Completion is keyed only to the WORDS-th valid.
- Last valid arriving while requests are still issuing cannot occur; no handling is required.
- Reset asserted mid-fill: immediate return to IDLE with all outputs low. Any later valids are ignored and no tag write occurs.
- Minimum fill occupancy is WORDS+L cycles. Back-to-back misses incur one IDLE cycle between fills.

## Test plan
- Aligned miss 0x1230, memory L=4: requests 0x1230,0x1232..0x123E in cycles 1-8; data writes cycles 5-12 at the same addresses; `write_tag_array` only in cycle 12; `fsm_busy` low in cycle 13.
- Unaligned miss 0x1236: `base` = 0x1230; identical address sequence to the aligned case; the first write goes to 0x1230, not 0x1236.
- Wrap case, miss 0xFFFA: `base` = 0xFFF0; last request is 0xFFFE; no carry into address 0x0000.
- Return valids with gaps (valid every other cycle after latency): 8 data writes at incrementing addresses; tag written only with the 8th valid.
- `rst` pulsed after 3 returned words: outputs 0 within the reset cycle; subsequent valids produce no writes; a new miss 0x0040 then performs a clean full fill.
- `miss_detected` held high through a fill with stray valids in IDLE: no writes in IDLE; the second fill starts exactly one cycle after `fsm_busy` drops and uses the newly latched address.
